// File: rtl/cache_pkg.sv
// Cache-side types, including the RAM arbiter state and owner encodings.
package cache_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_IGNT = 2'd1,
        ARB_DGNT = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/cpu_types_pkg.sv
// Shared CPU-wide types: machine word and RAM handshake status.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

endpackage

// File: rtl/cache_mem_arbiter.sv
// Arbitrates the icache and dcache onto one RAM port, holding dcache grants for block bursts.
// Build option ARB_FAIR_EN: round-robin between caches instead of fixed dcache priority.
module cache_mem_arbiter
    import cpu_types_pkg::*;
    import cache_pkg::*;
#(
    parameter int BURST_LEN = 2
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      iREN,
    input  word_t     iaddr,
    output logic      iwait,
    output word_t     iload,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      dwait,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate
);

    localparam int BW = $clog2(BURST_LEN + 1);

    arb_state_t    r_state, w_state_nxt;
    logic [BW-1:0] r_beat_cnt, w_beat_nxt;
    logic          w_dreq, w_access, w_dfirst;

    assign w_dreq   = dREN | dWEN;
    assign w_access = (ramstate == ACCESS);

`ifdef ARB_FAIR_EN
    arb_owner_t r_last_owner, w_last_nxt;

    // With both caches asking, the dcache yields only if it held the RAM last.
    assign w_dfirst = w_dreq & ~(iREN & (r_last_owner == OWN_D));
`else
    assign w_dfirst = w_dreq;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= ARB_IDLE;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_beat_cnt <= w_beat_nxt;
        end
    end

`ifdef ARB_FAIR_EN
    always_ff @(posedge CLK) begin
        if (RST) r_last_owner <= OWN_I;
        else     r_last_owner <= w_last_nxt;
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat_cnt;
`ifdef ARB_FAIR_EN
        w_last_nxt  = r_last_owner;
`endif
        case (r_state)
            ARB_IDLE: begin
                w_beat_nxt = '0;
                if (w_dfirst)  w_state_nxt = ARB_DGNT;
                else if (iREN) w_state_nxt = ARB_IGNT;
            end
            ARB_IGNT: begin
                if (!iREN || w_access) begin
                    w_state_nxt = ARB_IDLE;
`ifdef ARB_FAIR_EN
                    w_last_nxt  = OWN_I;
`endif
                end
            end
            ARB_DGNT: begin
                if (!w_dreq) begin
                    w_state_nxt = ARB_IDLE;
                    w_beat_nxt  = '0;
`ifdef ARB_FAIR_EN
                    w_last_nxt  = OWN_D;
`endif
                end else if (w_access) begin
                    // Last beat of the block releases the RAM; earlier beats keep the grant.
                    w_beat_nxt = r_beat_cnt + BW'(1);
                    if (w_beat_nxt == BW'(BURST_LEN)) begin
                        w_state_nxt = ARB_IDLE;
                        w_beat_nxt  = '0;
`ifdef ARB_FAIR_EN
                        w_last_nxt  = OWN_D;
`endif
                    end
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
                w_beat_nxt  = '0;
            end
        endcase
    end

    // RAM enables track the live request so a withdrawn request stops the RAM immediately.
    always_comb begin
        iwait    = 1'b1;
        dwait    = 1'b1;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        if (!RST) begin
            case (r_state)
                ARB_IGNT: begin
                    ramREN  = iREN;
                    ramaddr = iaddr;
                    iwait   = ~w_access;
                end
                ARB_DGNT: begin
                    ramREN   = dREN & ~dWEN;
                    ramWEN   = dWEN;
                    ramaddr  = daddr;
                    ramstore = dstore;
                    dwait    = ~w_access;
                end
                default: ;
            endcase
        end
    end

    assign iload = ramload;
    assign dload = ramload;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: directed scenarios plus randomized traffic vs an owner/beat model.
module tb_cache_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int BL = 2;

    logic      CLK = 1'b0;
    logic      RST;
    logic      iREN, dREN, dWEN;
    word_t     iaddr, daddr, dstore, ramload;
    ramstate_t ramstate;
    logic      iwait, dwait, ramREN, ramWEN;
    word_t     iload, dload, ramaddr, ramstore;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: who owns the RAM (0 nobody, 1 icache, 2 dcache), beats done, last owner.
    int m_own, m_beats, m_last;
    logic  e_iwait, e_dwait, e_ren, e_wen;
    word_t e_addr, e_store;

    cache_mem_arbiter #(.BURST_LEN(BL)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    task automatic model_eval();
        e_iwait = 1'b1; e_dwait = 1'b1; e_ren = 1'b0; e_wen = 1'b0;
        e_addr = '0; e_store = '0;
        if (!RST) begin
            if (m_own == 1) begin
                e_ren = iREN; e_addr = iaddr; e_iwait = (ramstate != ACCESS);
            end else if (m_own == 2) begin
                e_wen = dWEN; e_ren = dREN && !dWEN; e_addr = daddr; e_store = dstore;
                e_dwait = (ramstate != ACCESS);
            end
        end
    endtask

    task automatic model_advance();
        bit dreq;
        dreq = dREN || dWEN;
        if (RST) begin
            m_own = 0; m_beats = 0; m_last = 1;
        end else if (m_own == 0) begin
            m_beats = 0;
`ifdef ARB_FAIR_EN
            if (dreq && iREN) m_own = (m_last == 1) ? 2 : 1;
            else if (dreq)    m_own = 2;
            else if (iREN)    m_own = 1;
`else
            if (dreq)      m_own = 2;
            else if (iREN) m_own = 1;
`endif
        end else if (m_own == 1) begin
            if (!iREN || ramstate == ACCESS) begin m_own = 0; m_last = 1; end
        end else begin
            if (!dreq) begin
                m_own = 0; m_last = 2;
            end else if (ramstate == ACCESS) begin
                m_beats++;
                if (m_beats == BL) begin m_own = 0; m_last = 2; end
            end
        end
    endtask

    // Inputs are driven 1 time unit after the edge; outputs are sampled 2 units later.
    task automatic tick();
        model_advance();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        iREN = 0; dREN = 0; dWEN = 0; ramstate = FREE;
    endtask

    task automatic test_reset();
        RST = 1; iREN = 1; dREN = 1; dWEN = 0;
        iaddr = 32'h10; daddr = 32'h20; ramstate = ACCESS;
        for (int c = 0; c < 2; c++) begin
            ramload = $urandom;
            #2;
            n_cmp++;
            if (iwait !== 1'b1 || dwait !== 1'b1 || ramREN !== 1'b0 || ramWEN !== 1'b0) begin
                n_err++;
                $display("FAIL reset_outputs: iwait=%b dwait=%b ren=%b wen=%b, want 1 1 0 0",
                         iwait, dwait, ramREN, ramWEN);
            end
            n_cmp++;
            if (ramaddr !== 32'h0 || iload !== ramload || dload !== ramload) begin
                n_err++;
                $display("FAIL reset_data: addr=%h iload=%h dload=%h, want 0 and %h",
                         ramaddr, iload, dload, ramload);
            end
            tick();
        end
        RST = 0;
        #2;
        n_cmp++;
        if (ramREN !== 1'b0 || iwait !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release_idle: ren=%b iwait=%b, want 0 1", ramREN, iwait);
        end
        tick();
        #2;
        n_cmp++;
        if (ramREN !== 1'b1 || ramaddr !== 32'h20 || dwait !== 1'b0 || iwait !== 1'b1) begin
            n_err++;
            $display("FAIL reset_first_grant_d: ren=%b addr=%h dwait=%b iwait=%b, want 1 20 0 1",
                     ramREN, ramaddr, dwait, iwait);
        end
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_icache_read();
        iREN = 1; iaddr = 32'h40; ramstate = ACCESS; ramload = 32'h2408_0001;
        #2;
        n_cmp++;
        if (ramREN !== 1'b0 || iwait !== 1'b1) begin
            n_err++;
            $display("FAIL iread_cycleN: ren=%b iwait=%b, want 0 1", ramREN, iwait);
        end
        tick();
        #2;
        n_cmp++;
        if (ramREN !== 1'b1 || ramaddr !== 32'h40 || iwait !== 1'b0 || iload !== 32'h2408_0001) begin
            n_err++;
            $display("FAIL iread_cycleN1: ren=%b addr=%h iwait=%b iload=%h, want 1 40 0 24080001",
                     ramREN, ramaddr, iwait, iload);
        end
        tick();
        #2;
        n_cmp++;
        if (ramREN !== 1'b0 || iwait !== 1'b1) begin
            n_err++;
            $display("FAIL iread_idle_gap: ren=%b iwait=%b, want 0 1", ramREN, iwait);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_dburst();
        int dlow;
        dlow = 0;
        dWEN = 1; dREN = 0; daddr = 32'h100; dstore = $urandom;
        iREN = 1; iaddr = 32'h80; ramstate = BUSY;
        #2;
        n_cmp++;
        if (ramWEN !== 1'b0) begin
            n_err++;
            $display("FAIL dburst_idle: wen=%b, want 0", ramWEN);
        end
        tick();
        for (int g = 0; g < 6; g++) begin
            ramstate = (g % 3 == 2) ? ACCESS : BUSY;
            daddr    = (g < 3) ? 32'h100 : 32'h104;
            #2;
            n_cmp++;
            if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramaddr !== daddr ||
                ramstore !== dstore || iwait !== 1'b1) begin
                n_err++;
                $display("FAIL dburst_beat%0d: wen=%b ren=%b addr=%h store=%h iwait=%b, want 1 0 %h %h 1",
                         g, ramWEN, ramREN, ramaddr, ramstore, iwait, daddr, dstore);
            end
            if (dwait === 1'b0) dlow++;
            tick();
        end
        n_cmp++;
        if (dlow != 2) begin
            n_err++;
            $display("FAIL dburst_dwait_count: got %0d low beats, want 2", dlow);
        end
        dWEN = 0; ramstate = ACCESS;
        #2;
        n_cmp++;
        if (ramWEN !== 1'b0 || ramREN !== 1'b0 || iwait !== 1'b1) begin
            n_err++;
            $display("FAIL dburst_gap: wen=%b ren=%b iwait=%b, want 0 0 1", ramWEN, ramREN, iwait);
        end
        tick();
        #2;
        n_cmp++;
        if (iwait !== 1'b0 || ramaddr !== 32'h80) begin
            n_err++;
            $display("FAIL dburst_then_i: iwait=%b addr=%h, want 0 80", iwait, ramaddr);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_withdraw();
        int dlow;
        dlow = 0;
        dREN = 1; dWEN = 0; daddr = 32'h300; ramstate = ACCESS;
        tick();
        #2;
        n_cmp++;
        if (ramREN !== 1'b1 || dwait !== 1'b0) begin
            n_err++;
            $display("FAIL wd_first_beat: ren=%b dwait=%b, want 1 0", ramREN, dwait);
        end
        ramstate = BUSY;
        tick();
        dREN = 0;
        #2;
        n_cmp++;
        if (ramREN !== 1'b0) begin
            n_err++;
            $display("FAIL wd_same_cycle: ren=%b, want 0", ramREN);
        end
        tick();
        dREN = 1; ramstate = ACCESS;
        #2;
        n_cmp++;
        if (ramREN !== 1'b0 || dwait !== 1'b1) begin
            n_err++;
            $display("FAIL wd_idle_next: ren=%b dwait=%b, want 0 1", ramREN, dwait);
        end
        tick();
        // Fresh grant after withdrawal must run a full block from beat zero.
        for (int c = 0; c < 3; c++) begin
            #2;
            if (dwait === 1'b0) dlow++;
            tick();
        end
        n_cmp++;
        if (dlow != 2) begin
            n_err++;
            $display("FAIL wd_beats_restart: got %0d beats, want 2", dlow);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_midburst();
        dWEN = 1; dREN = 0; daddr = 32'h400; ramstate = ACCESS;
        tick();
        #2;
        n_cmp++;
        if (ramWEN !== 1'b1 || dwait !== 1'b0) begin
            n_err++;
            $display("FAIL rmb_beat1: wen=%b dwait=%b, want 1 0", ramWEN, dwait);
        end
        tick();
        RST = 1; daddr = 32'h404;
        #2;
        n_cmp++;
        if (ramWEN !== 1'b0 || dwait !== 1'b1) begin
            n_err++;
            $display("FAIL rmb_in_reset: wen=%b dwait=%b, want 0 1", ramWEN, dwait);
        end
        tick();
        RST = 0;
        #2;
        n_cmp++;
        if (ramWEN !== 1'b0) begin
            n_err++;
            $display("FAIL rmb_idle_after: wen=%b, want 0", ramWEN);
        end
        tick();
        #2;
        n_cmp++;
        if (ramWEN !== 1'b1) begin
            n_err++;
            $display("FAIL rmb_regrant: wen=%b, want 1", ramWEN);
        end
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_contention();
        int icnt, dcnt, first;
        icnt = 0; dcnt = 0; first = 0;
        RST = 1; idle_inputs();
        tick();
        RST = 0;
        iREN = 1; dREN = 1; iaddr = 32'h500; daddr = 32'h600; ramstate = ACCESS;
        for (int c = 0; c < 20; c++) begin
            #2;
            if (iwait === 1'b0) begin icnt++; if (first == 0) first = 1; end
            if (dwait === 1'b0) begin dcnt++; if (first == 0) first = 2; end
            tick();
        end
`ifdef ARB_FAIR_EN
        n_cmp++;
        if (icnt != 4 || dcnt != 8 || first != 2) begin
            n_err++;
            $display("FAIL contention_fair: i=%0d d=%0d first=%0d, want 4 8 2", icnt, dcnt, first);
        end
`else
        n_cmp++;
        if (icnt != 0 || dcnt != 13 || first != 2) begin
            n_err++;
            $display("FAIL contention_fixed: i=%0d d=%0d first=%0d, want 0 13 2", icnt, dcnt, first);
        end
`endif
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            RST      = ($urandom_range(0, 49) == 0);
            iREN     = ($urandom_range(0, 2) != 0);
            dREN     = ($urandom_range(0, 2) == 0);
            dWEN     = ($urandom_range(0, 3) == 0);
            iaddr    = $urandom;
            daddr    = $urandom;
            dstore   = $urandom;
            ramload  = $urandom;
            ramstate = ramstate_t'($urandom_range(0, 3));
            #2;
            model_eval();
            n_cmp++;
            if (iwait !== e_iwait || dwait !== e_dwait || ramREN !== e_ren || ramWEN !== e_wen) begin
                n_err++;
                $display("FAIL rand_ctl c=%0d: iw=%b dw=%b ren=%b wen=%b, want %b %b %b %b",
                         c, iwait, dwait, ramREN, ramWEN, e_iwait, e_dwait, e_ren, e_wen);
            end
            n_cmp++;
            if (iload !== ramload || dload !== ramload ||
                ((RST || m_own != 0) && ramaddr !== e_addr) ||
                ((RST || m_own == 2) && ramstore !== e_store)) begin
                n_err++;
                $display("FAIL rand_data c=%0d: addr=%h store=%h il=%h dl=%h, want %h %h %h",
                         c, ramaddr, ramstore, iload, dload, e_addr, e_store, ramload);
            end
            tick();
        end
        RST = 0; idle_inputs();
        tick();
    endtask

    initial begin
        m_own = 0; m_beats = 0; m_last = 1;
        RST = 1; idle_inputs();
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0;
        @(posedge CLK);
        #1;
        test_reset();
        test_icache_read();
        test_dburst();
        test_withdraw();
        test_reset_midburst();
        test_contention();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

- Sits between the instruction cache and data cache controllers and the single-ported RAM.
- Accepts word requests from both caches, grants one owner at a time, and drives the RAM address/control/store lines.
- Returns wait/load to the owning cache and holds the grant for the data cache's two-word block bursts (write-back, load, flush).

## Interface
Parameters:
- BURST_LEN, 2, maximum ACCESS beats one dcache grant may cover (matches DBLK_W+1 words per block)

Ports:
- CLK  in  1  system clock, all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- iREN  in  1  icache read request
- iaddr  in  32  icache word address
- iwait  out  1  icache stall; low only in the completing beat
- iload  out  32  read data to icache
- dREN  in  1  dcache read request
- dWEN  in  1  dcache write request
- daddr  in  32  dcache word address
- dstore  in  32  dcache write data
- dwait  out  1  dcache stall; low only in a completing beat
- dload  out  32  read data to dcache
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  ramstate_t  RAM status: FREE, BUSY, ACCESS, ERROR

## Operation
States (arb_state_t):
- ARB_IDLE: no RAM enables asserted.
- ARB_IGNT: icache owns RAM; ramREN=iREN, ramaddr=iaddr.
- ARB_DGNT: dcache owns RAM; ramREN=dREN&~dWEN, ramWEN=dWEN, ramaddr=daddr, ramstore=dstore.

Transitions:
- ARB_IDLE: if a dcache request (dREN|dWEN) is pending, go to ARB_DGNT. Otherwise, if iREN is pending, go to ARB_IGNT. Fairness rule under Configuration.
- ARB_IGNT, beat complete (ramstate==ACCESS): go to ARB_IDLE after one beat.
- ARB_DGNT: stays while dcache request holds and beat_cnt<BURST_LEN; each ACCESS increments beat_cnt. Exit to ARB_IDLE on the BURST_LEN-th ACCESS, or when dcache drops its request.
- Requester drops its request before ACCESS: go to ARB_IDLE next cycle; RAM enables drop in that same cycle, because enables follow the live request.

Completion and data:
- iwait = ~(state==ARB_IGNT && ramstate==ACCESS); dwait likewise for ARB_DGNT.
- iload = dload = ramload, combinational.

Edge cases:
- dREN and dWEN together: illegal; dWEN wins.
- ramstate BUSY, FREE or ERROR while granted: no completion, grant held, retry.
- beat_cnt: width $clog2(BURST_LEN+1); cleared on every entry to ARB_DGNT and in ARB_IDLE; never wraps.
- Reset:
  - While RST is high, all outputs are forced to reset values combinationally.
  - On the edge: state=ARB_IDLE, beat_cnt=0, last_owner=OWN_I.
  - Reset mid-burst abandons the access; the caches are reset by the same RST.
- Reset output values: iwait=1, dwait=1, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iload/dload=ramload.

## Timing
- Arbitration decision is registered. A request first seen in ARB_IDLE at cycle N drives RAM enables from cycle N+1.
- Zero-wait RAM (ACCESS in the first granted cycle): icache read latency 2 cycles from request. A dcache 2-word burst completes in 3 cycles.
- After a completing beat, ARB_IDLE follows for exactly one cycle before any new grant, except back-to-back dcache burst beats, which have no gap.
- Outputs are combinational from state, beat_cnt and inputs. Nothing in the RAM path is registered.

## Configuration
- ARB_FAIR_EN defined:
  - Round-robin on last_owner, a flop updated on each grant exit.
  - In ARB_IDLE with both requesting, the owner opposite last_owner wins.
  - Worst-case icache wait is one dcache burst.
- ARB_FAIR_EN undefined:
  - Fixed dcache priority.
  - last_owner flop removed.
  - icache may starve while dcache requests continuously.

## Structure
- Add to cache_pkg:
  - arb_state_t, logic[1:0] enum: ARB_IDLE, ARB_IGNT, ARB_DGNT
  - arb_owner_t, 1-bit enum: OWN_I, OWN_D
- ramstate_t and word_t come from cpu_types_pkg.
- Single flat module; no sub-module is warranted.

## Test plan
- Reset: RST high 2 cycles with iREN=1 and dREN=1 -> iwait=dwait=1, ramREN=ramWEN=0 throughout; first grant goes to dcache in the cycle after RST falls.
- icache read: iREN=1, iaddr=0x0000_0040, ramstate=ACCESS, ramload=0x2408_0001 -> ramREN=1 and ramaddr=0x40 at N+1; iwait=0 and iload=0x2408_0001 at N+1; ARB_IDLE at N+2.
- dcache write-back burst: dWEN=1, daddr 0x100 then 0x104, RAM BUSY 2 cycles per beat -> grant held 6 cycles; dwait low exactly twice; iREN held high sees iwait=1 until the burst ends.
- Contention with ARB_FAIR_EN: both request continuously -> owners alternate D, I, D, I; each icache read completes between dcache bursts. Without the macro, icache never granted while dREN is held.
- Request withdrawal: dREN dropped after 1 BUSY cycle in ARB_DGNT -> ramREN=0 in the same cycle; ARB_IDLE the next; beat_cnt=0.
- Reset mid-burst: RST asserted after the first ACCESS beat -> state ARB_IDLE; no second beat issued; ramWEN=0 while RST is high.
